digit_entry_conditioner: RTL and testbench

- Upstream input stage for the 6-digit combination-lock state machine.
- Synchronizes and debounces the raw insert push-button and the 4-bit digit switches, rejects non-decimal digits, and counts accepted digits.
- Issues exactly one clean, active-low, single-cycle insere strobe per accepted press, with a registered number that is stable while the strobe is low.

---
 rtl/digit_entry_conditioner.sv | 147 ++++++++++++++
 tb/tb_digit_entry_conditioner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry_conditioner.sv
// Insert-button / digit-switch conditioner feeding the combination-lock FSM.
// Optional idle timeout enabled by defining ENTRY_TIMEOUT_EN.
module digit_entry_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 6,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic [3:0] number_raw,
    input  logic       clear,
    output logic       insere,
    output logic [3:0] number,
    output logic       invalid_digit,
    output logic       entry_full,
    output logic [3:0] digit_count,
    output logic       timeout
);

    localparam int              DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      MAX_CNT = 4'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t          state, state_next;
    logic [DB_W-1:0] db_cnt, db_cnt_next;
    logic            btn_meta, btn_s;
    logic [3:0]      num_meta, num_s;
    logic            press_done, accept, reject, timeout_hit;

    // Button idles released (high); switches idle at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_meta <= 1'b1;
            btn_s    <= 1'b1;
            num_meta <= '0;
            num_s    <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_s    <= btn_meta;
            num_meta <= number_raw;
            num_s    <= num_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            state  <= state_next;
            db_cnt <= db_cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        db_cnt_next = db_cnt;
        unique case (state)
            IDLE: begin
                if (!btn_s) begin
                    state_next  = PRESS_WAIT;
                    db_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (btn_s)                 state_next  = IDLE;
                else if (db_cnt == DB_LAST) state_next = HELD;
                else                       db_cnt_next = db_cnt + 1'b1;
            end
            HELD: begin
                if (btn_s) begin
                    state_next  = RELEASE_WAIT;
                    db_cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!btn_s)                state_next  = HELD;
                else if (db_cnt == DB_LAST) state_next = IDLE;
                else                       db_cnt_next = db_cnt + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // A full entry swallows the press entirely, including the invalid pulse.
    always_comb begin
        press_done = (state == PRESS_WAIT) && !btn_s && (db_cnt == DB_LAST);
        accept     = press_done && (num_s <= 4'd9) && (digit_count < MAX_CNT);
        reject     = press_done && (num_s >  4'd9) && (digit_count < MAX_CNT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            insere        <= 1'b1;
            number        <= '0;
            invalid_digit <= 1'b0;
            digit_count   <= '0;
        end else begin
            insere        <= !accept;
            invalid_digit <= reject;
            if (accept) begin
                number      <= num_s;
                digit_count <= clear ? 4'd1 : digit_count + 4'd1;
            end else if (clear || timeout_hit) begin
                digit_count <= '0;
            end
        end
    end

    assign entry_full = (digit_count == MAX_CNT);

`ifdef ENTRY_TIMEOUT_EN
    localparam int              IDLE_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_run;

    assign idle_run    = (digit_count != 4'd0) && (digit_count < MAX_CNT);
    // An accept or clear in the same cycle takes precedence over the timeout.
    assign timeout_hit = idle_run && !accept && !clear && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= timeout_hit;
            if (accept || clear || timeout_hit) idle_cnt <= '0;
            else if (idle_run)                  idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // Parameter still referenced so both builds share one parameter list.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_digit_entry_conditioner.sv
// Scoreboard bench for digit_entry_conditioner; a second instance with a short
// timeout exercises the ENTRY_TIMEOUT_EN path when that macro is defined.
module tb_digit_entry_conditioner;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic [3:0] number_raw;
    logic       clear;

    logic       insere, invalid_digit, entry_full, timeout;
    logic [3:0] number, digit_count;
    logic       to_insere, to_invalid, to_full, to_timeout;
    logic [3:0] to_number, to_count;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int invalid_cnt = 0;
    int model_count = 0;

    typedef struct {
        logic [3:0] num;
        logic [3:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    digit_entry_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .MAX_DIGITS(6),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clock(clock), .reset(reset), .btn_raw(btn_raw), .number_raw(number_raw),
        .clear(clear), .insere(insere), .number(number), .invalid_digit(invalid_digit),
        .entry_full(entry_full), .digit_count(digit_count), .timeout(timeout)
    );

    digit_entry_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .MAX_DIGITS(6),
        .TIMEOUT_CYCLES(20)
    ) dut_to (
        .clock(clock), .reset(reset), .btn_raw(btn_raw), .number_raw(number_raw),
        .clear(clear), .insere(to_insere), .number(to_number), .invalid_digit(to_invalid),
        .entry_full(to_full), .digit_count(to_count), .timeout(to_timeout)
    );

    always #5 clock = ~clock;

    // Strobe monitor: every insere low cycle must match the next expected digit.
    always @(negedge clock) begin
        if (reset === 1'b1 && insere === 1'b0) begin
            strobe_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe number=%0d count=%0d required no strobe", number, digit_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (number !== e.num || digit_count !== e.cnt) begin
                    errors++;
                    $display("FAIL strobe number=%0d count=%0d required number=%0d count=%0d",
                             number, digit_count, e.num, e.cnt);
                end
            end
        end
        if (reset === 1'b1 && invalid_digit === 1'b1) invalid_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic press(input logic [3:0] d, input int hold, input int gap);
        if (d <= 4'd9 && model_count < 6) begin
            model_count++;
            exp_q.push_back('{num: d, cnt: 4'(model_count)});
        end
        number_raw = d;
        btn_raw    = 1'b0;
        repeat (hold) tick();
        btn_raw    = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_count = 0;
    endtask

    task automatic test_reset();
        int lat;
        reset = 1'b0; btn_raw = 1'b0; number_raw = 4'd3; clear = 1'b0;
        repeat (5) tick();
        checks++; if (insere !== 1'b1) begin errors++; $display("FAIL reset_insere got=%b exp=1", insere); end
        checks++; if (number !== 4'd0) begin errors++; $display("FAIL reset_number got=%0d exp=0", number); end
        checks++; if (invalid_digit !== 1'b0) begin errors++; $display("FAIL reset_invalid got=%b exp=0", invalid_digit); end
        checks++; if (entry_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", entry_full); end
        checks++; if (digit_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", digit_count); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        model_count = 1;
        exp_q.push_back('{num: 4'd3, cnt: 4'd1});
        reset = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (insere !== 1'b0 && lat < 20);
        checks++; if (lat != 7) begin errors++; $display("FAIL first_strobe_latency got=%0d exp=7", lat); end
        btn_raw = 1'b1;
        repeat (12) tick();
        pulse_clear();
        checks++; if (digit_count !== 4'd0) begin errors++; $display("FAIL clear_count got=%0d exp=0", digit_count); end
    endtask

    task automatic test_sequence();
        logic [3:0] digits [6] = '{4'd5, 4'd7, 4'd5, 4'd1, 4'd6, 4'd4};
        int s0 = strobe_cnt;
        for (int i = 0; i < 6; i++) begin
            press(digits[i], 10, 12);
            checks++;
            if (digit_count !== 4'(model_count)) begin
                errors++;
                $display("FAIL seq_count[%0d] got=%0d exp=%0d", i, digit_count, model_count);
            end
        end
        checks++; if (entry_full !== 1'b1) begin errors++; $display("FAIL seq_full got=%b exp=1", entry_full); end
        checks++; if (strobe_cnt - s0 != 6) begin errors++; $display("FAIL seq_strobes got=%0d exp=6", strobe_cnt - s0); end
        checks++; if (number !== 4'd4) begin errors++; $display("FAIL seq_number got=%0d exp=4", number); end
    endtask

    task automatic test_full();
        int s0 = strobe_cnt;
        press(4'd2, 10, 12);
        checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL full_strobe got=%0d exp=0", strobe_cnt - s0); end
        checks++; if (digit_count !== 4'd6) begin errors++; $display("FAIL full_count got=%0d exp=6", digit_count); end
        checks++; if (number !== 4'd4) begin errors++; $display("FAIL full_number got=%0d exp=4", number); end
        pulse_clear();
        checks++; if (digit_count !== 4'd0 || entry_full !== 1'b0) begin
            errors++; $display("FAIL full_clear count=%0d full=%b exp count=0 full=0", digit_count, entry_full);
        end
    endtask

    task automatic test_bounce();
        int s0 = strobe_cnt;
        model_count++;
        exp_q.push_back('{num: 4'd9, cnt: 4'(model_count)});
        number_raw = 4'd9;
        btn_raw = 1'b0; repeat (2) tick();
        btn_raw = 1'b1; repeat (1) tick();
        btn_raw = 1'b0; repeat (10) tick();
        btn_raw = 1'b1; repeat (2) tick();
        btn_raw = 1'b0; repeat (1) tick();
        btn_raw = 1'b1; repeat (12) tick();
        checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL bounce_strobes got=%0d exp=1", strobe_cnt - s0); end
        checks++; if (digit_count !== 4'd1) begin errors++; $display("FAIL bounce_count got=%0d exp=1", digit_count); end
        checks++; if (number !== 4'd9) begin errors++; $display("FAIL bounce_number got=%0d exp=9", number); end
    endtask

    task automatic test_invalid();
        int s0 = strobe_cnt;
        int i0 = invalid_cnt;
        press(4'd12, 10, 12);
        checks++; if (invalid_cnt - i0 != 1) begin errors++; $display("FAIL invalid_pulses got=%0d exp=1", invalid_cnt - i0); end
        checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL invalid_strobe got=%0d exp=0", strobe_cnt - s0); end
        checks++; if (number !== 4'd9) begin errors++; $display("FAIL invalid_number got=%0d exp=9", number); end
        checks++; if (digit_count !== 4'd1) begin errors++; $display("FAIL invalid_count got=%0d exp=1", digit_count); end
    endtask

    task automatic test_clear_accept();
        int s0;
        press(4'd1, 10, 12);
        press(4'd2, 10, 12);
        checks++; if (digit_count !== 4'd3) begin errors++; $display("FAIL pre_clear_count got=%0d exp=3", digit_count); end
        s0 = strobe_cnt;
        model_count = 1;
        exp_q.push_back('{num: 4'd8, cnt: 4'd1});
        number_raw = 4'd8;
        btn_raw = 1'b0;
        repeat (6) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (insere !== 1'b0) begin errors++; $display("FAIL clear_accept_insere got=%b exp=0", insere); end
        checks++; if (digit_count !== 4'd1) begin errors++; $display("FAIL clear_accept_count got=%0d exp=1", digit_count); end
        repeat (3) tick();
        btn_raw = 1'b1;
        repeat (12) tick();
        checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL clear_accept_strobes got=%0d exp=1", strobe_cnt - s0); end
    endtask

    task automatic test_timeout();
        int lat;
        int n;
        pulse_clear();
        press(4'd3, 8, 8);
        model_count++;
        exp_q.push_back('{num: 4'd6, cnt: 4'(model_count)});
        number_raw = 4'd6;
        btn_raw = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (to_insere !== 1'b0 && lat < 20);
        checks++; if (lat != 7) begin errors++; $display("FAIL timeout_strobe_latency got=%0d exp=7", lat); end
        checks++; if (to_count !== 4'd2) begin errors++; $display("FAIL timeout_pre_count got=%0d exp=2", to_count); end
        btn_raw = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (to_timeout !== 1'b1 && n < 40);
`ifdef ENTRY_TIMEOUT_EN
        checks++; if (n != 20) begin errors++; $display("FAIL timeout_delay got=%0d exp=20", n); end
        checks++; if (to_count !== 4'd0) begin errors++; $display("FAIL timeout_count got=%0d exp=0", to_count); end
`else
        checks++; if (to_timeout !== 1'b0) begin errors++; $display("FAIL timeout_tied got=%b exp=0", to_timeout); end
        checks++; if (to_count !== 4'd2) begin errors++; $display("FAIL timeout_count got=%0d exp=2", to_count); end
`endif
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL main_timeout got=%b exp=0", timeout); end
        checks++; if (digit_count !== 4'd2) begin errors++; $display("FAIL main_count got=%0d exp=2", digit_count); end
    endtask

    initial begin
        reset = 1'b0; btn_raw = 1'b1; number_raw = 4'd0; clear = 1'b0;
        test_reset();
        test_sequence();
        test_full();
        test_bounce();
        test_invalid();
        test_clear_accept();
        test_timeout();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes got=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
